window_mapper_gen: RTL and testbench

- Parametrised next-generation sliding-window mapper for the sparse HDC accelerator; sits between the input stream and the item-memory/binding stage.
- Buffers a window of symbols and replays each window position as one output beat, carrying the symbol, shift amount and an unfilled-slot flag.
- Adds, per beat, configurable symbol width, window depth and stride, full valid/ready backpressure on both sides, and a registered pass-through mode.

---
 rtl/window_mapper_gen_if.sv | 39 +++
 rtl/window_mapper_gen.sv | 169 ++++++++++++++++
 tb/tb_window_mapper_gen.sv | 299 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/window_mapper_gen_if.sv
// Handshake and configuration bundle between the input stream, the window mapper
// and the item-memory/binding stage.
interface window_mapper_gen_if #(
    parameter int SYM_W   = 6,
    parameter int MAX_WIN = 16,
    parameter int SHIFT_W = 6,
    parameter int WIN_W   = $clog2(MAX_WIN + 1)
);
    logic               soft_clear_i;
    logic               running_i;
    logic               window_mode_i;
    logic               sig_mode_i;
    logic [WIN_W-1:0]   win_size_i;
    logic [WIN_W-1:0]   stride_i;
    logic [SHIFT_W-1:0] shift_in_i;
    logic               in_valid_i;
    logic [SYM_W-1:0]   in_symbol_i;
    logic               in_ready_o;
    logic               out_valid_o;
    logic               out_ready_i;
    logic [SYM_W-1:0]   out_symbol_o;
    logic [SHIFT_W-1:0] out_shift_o;
    logic               out_zero_o;
    logic               out_last_o;

    modport slave (
        input  soft_clear_i, running_i, window_mode_i, sig_mode_i,
        input  win_size_i, stride_i, shift_in_i,
        input  in_valid_i, in_symbol_i, out_ready_i,
        output in_ready_o, out_valid_o, out_symbol_o, out_shift_o, out_zero_o, out_last_o
    );

    modport master (
        output soft_clear_i, running_i, window_mode_i, sig_mode_i,
        output win_size_i, stride_i, shift_in_i,
        output in_valid_i, in_symbol_i, out_ready_i,
        input  in_ready_o, out_valid_o, out_symbol_o, out_shift_o, out_zero_o, out_last_o
    );
endinterface

// File: rtl/window_mapper_gen.sv
// Sliding-window mapper: buffers symbols in a shift queue and replays each window
// position as one beat (symbol, shift, unfilled flag), or forwards symbols in pass-through.
module window_mapper_gen #(
    parameter int SYM_W   = 6,
    parameter int MAX_WIN = 16,
    parameter int SHIFT_W = 6,
    parameter int WIN_W   = $clog2(MAX_WIN + 1)
) (
    input  logic                clk_i,
    input  logic                rst_i,
    window_mapper_gen_if.slave  bus
);
    localparam int IDX_W = (MAX_WIN > 1) ? $clog2(MAX_WIN) : 1;
    localparam logic [0:0] ST_LOAD = 1'b0;
    localparam logic [0:0] ST_EMIT = 1'b1;

    logic [0:0]         state_reg, state_next;
    logic [SYM_W-1:0]   q_reg    [MAX_WIN];
    logic [SYM_W-1:0]   q_shift  [MAX_WIN];
    logic [SYM_W-1:0]   q_masked [MAX_WIN];
    logic [MAX_WIN-1:0] fill_reg;
    logic [WIN_W-1:0]   pos_reg, pos_next;
    logic [WIN_W-1:0]   load_cnt_reg, load_cnt_next;
    logic               pt_valid_reg, pt_valid_next;
    logic [SYM_W-1:0]   pt_symbol_reg;
    logic [SHIFT_W-1:0] pt_shift_reg;

    logic [WIN_W-1:0]   win_size_c, stride_c;
    logic [IDX_W-1:0]   pos_idx;
    logic [SYM_W-1:0]   xor_all;
    logic [SHIFT_W-1:0] sig_shift;
    logic               last_w, in_ready_w, out_valid_w, in_fire, out_fire;

    assign win_size_c = (bus.win_size_i == '0) ? WIN_W'(1) :
                        (bus.win_size_i > WIN_W'(MAX_WIN)) ? WIN_W'(MAX_WIN) : bus.win_size_i;
    assign stride_c   = (bus.stride_i == '0) ? WIN_W'(1) :
                        (bus.stride_i > WIN_W'(MAX_WIN)) ? WIN_W'(MAX_WIN) : bus.stride_i;

    // Positions never exceed MAX_WIN-1 because the window size is clamped.
    assign pos_idx = pos_reg[IDX_W-1:0];
    assign last_w  = (pos_reg == win_size_c - WIN_W'(1));

    genvar gi;
    generate
        for (gi = 0; gi < MAX_WIN; gi++) begin : g_slot
            if (gi == 0) begin : g_head
                assign q_shift[gi] = bus.in_symbol_i;
            end else begin : g_tail
                assign q_shift[gi] = q_reg[gi-1];
            end
            assign q_masked[gi] = (WIN_W'(gi) < win_size_c) ? q_reg[gi] : '0;
        end
    endgenerate

    always_comb begin
        xor_all = '0;
        for (int i = 0; i < MAX_WIN; i++) begin
            xor_all = xor_all ^ q_masked[i];
        end
    end

    assign sig_shift = SHIFT_W'(pos_reg) + SHIFT_W'(xor_all ^ q_reg[pos_idx]);

    always_comb begin
        in_ready_w       = 1'b0;
        out_valid_w      = 1'b0;
        bus.out_symbol_o = '0;
        bus.out_shift_o  = '0;
        bus.out_zero_o   = 1'b0;
        bus.out_last_o   = 1'b0;
        if (bus.window_mode_i) begin
            in_ready_w = (state_reg == ST_LOAD) && bus.running_i;
            if (state_reg == ST_EMIT) begin
                out_valid_w      = 1'b1;
                bus.out_symbol_o = q_reg[pos_idx];
                bus.out_shift_o  = bus.sig_mode_i ? sig_shift : SHIFT_W'(pos_reg);
                bus.out_zero_o   = !fill_reg[pos_idx];
                bus.out_last_o   = last_w;
            end
        end else begin
            in_ready_w       = bus.running_i && (!pt_valid_reg || bus.out_ready_i);
            out_valid_w      = pt_valid_reg;
            bus.out_symbol_o = pt_symbol_reg;
            bus.out_shift_o  = pt_shift_reg;
            bus.out_last_o   = pt_valid_reg;
        end
    end

    assign bus.in_ready_o  = in_ready_w;
    assign bus.out_valid_o = out_valid_w;
    assign in_fire  = bus.in_valid_i && in_ready_w;
    assign out_fire = out_valid_w && bus.out_ready_i;

    always_comb begin
        state_next    = state_reg;
        pos_next      = pos_reg;
        load_cnt_next = load_cnt_reg;
        pt_valid_next = pt_valid_reg;
        if (bus.window_mode_i) begin
            pt_valid_next = 1'b0;
            if (state_reg == ST_LOAD) begin
                if (in_fire) begin
                    if (load_cnt_reg == stride_c - WIN_W'(1)) begin
                        load_cnt_next = '0;
                        pos_next      = '0;
                        state_next    = ST_EMIT;
                    end else begin
                        load_cnt_next = load_cnt_reg + WIN_W'(1);
                    end
                end
            end else if (out_fire) begin
                if (last_w) begin
                    state_next = ST_LOAD;
                    pos_next   = '0;
                end else begin
                    pos_next = pos_reg + WIN_W'(1);
                end
            end
        end else begin
            state_next    = ST_LOAD;
            pos_next      = '0;
            load_cnt_next = '0;
            if (in_fire) begin
                pt_valid_next = 1'b1;
            end else if (out_fire) begin
                pt_valid_next = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_reg     <= ST_LOAD;
            fill_reg      <= '0;
            pos_reg       <= '0;
            load_cnt_reg  <= '0;
            pt_valid_reg  <= 1'b0;
            pt_symbol_reg <= '0;
            pt_shift_reg  <= '0;
            for (int i = 0; i < MAX_WIN; i++) q_reg[i] <= '0;
        end else if (bus.soft_clear_i) begin
            state_reg     <= ST_LOAD;
            fill_reg      <= '0;
            pos_reg       <= '0;
            load_cnt_reg  <= '0;
            pt_valid_reg  <= 1'b0;
            pt_symbol_reg <= '0;
            pt_shift_reg  <= '0;
            for (int i = 0; i < MAX_WIN; i++) q_reg[i] <= '0;
        end else begin
            state_reg    <= state_next;
            pos_reg      <= pos_next;
            load_cnt_reg <= load_cnt_next;
            pt_valid_reg <= pt_valid_next;
            if (!bus.window_mode_i) begin
                // Queue stays empty so a later switch to window mode starts clean.
                fill_reg <= '0;
                for (int i = 0; i < MAX_WIN; i++) q_reg[i] <= '0;
                if (in_fire) begin
                    pt_symbol_reg <= bus.in_symbol_i;
                    pt_shift_reg  <= bus.shift_in_i;
                end
            end else if (in_fire) begin
                fill_reg <= {fill_reg[MAX_WIN-2:0], 1'b1};
                for (int i = 0; i < MAX_WIN; i++) q_reg[i] <= q_shift[i];
            end
        end
    end
endmodule

// File: tb/tb_window_mapper_gen.sv
// Directed bench for window_mapper_gen: expected beats are queued when stimulus is
// issued and a monitor pops and compares them on every output transfer.
module tb_window_mapper_gen;
    localparam int SYM_W   = 6;
    localparam int MAX_WIN = 16;
    localparam int SHIFT_W = 6;
    localparam int WIN_W   = $clog2(MAX_WIN + 1);

    logic clk_i = 1'b0;
    logic rst_i;

    window_mapper_gen_if #(.SYM_W(SYM_W), .MAX_WIN(MAX_WIN), .SHIFT_W(SHIFT_W), .WIN_W(WIN_W)) bus ();

    window_mapper_gen #(.SYM_W(SYM_W), .MAX_WIN(MAX_WIN), .SHIFT_W(SHIFT_W), .WIN_W(WIN_W)) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic [SYM_W-1:0]   sym;
        logic [SHIFT_W-1:0] shift;
        logic               zero;
        logic               last;
    } beat_t;

    beat_t exp_q[$];
    int n_checks = 0;
    int n_fail   = 0;
    int n_beats  = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic push(input int sym, input int shift, input int zero, input int last);
        beat_t e;
        e.sym   = SYM_W'(sym);
        e.shift = SHIFT_W'(shift);
        e.zero  = zero[0];
        e.last  = last[0];
        exp_q.push_back(e);
    endtask

    // Monitor: one comparison set per output transfer.
    initial begin
        beat_t e;
        forever begin
            @(negedge clk_i);
            if (!rst_i && bus.out_valid_o && bus.out_ready_i) begin
                $display("beat %0d: sym=%0d shift=%0d zero=%0d last=%0d", n_beats,
                         bus.out_symbol_o, bus.out_shift_o, bus.out_zero_o, bus.out_last_o);
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_beat: got sym %0d, expected no beat", bus.out_symbol_o);
                end else begin
                    e = exp_q.pop_front();
                    check("beat_sym",   int'(bus.out_symbol_o), int'(e.sym));
                    check("beat_shift", int'(bus.out_shift_o),  int'(e.shift));
                    check("beat_zero",  int'(bus.out_zero_o),   int'(e.zero));
                    check("beat_last",  int'(bus.out_last_o),   int'(e.last));
                end
                n_beats++;
            end
            if (!rst_i && bus.window_mode_i && bus.out_valid_o)
                check("in_ready_during_emit", int'(bus.in_ready_o), 0);
        end
    end

    task automatic send_sym(input int sym);
        int waited = 0;
        bus.in_symbol_i = SYM_W'(sym);
        bus.in_valid_i  = 1'b1;
        @(negedge clk_i);
        while (!bus.in_ready_o && waited < 500) begin
            waited++;
            @(negedge clk_i);
        end
        if (!bus.in_ready_o) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_timeout: in_ready_o got 0, expected 1 for sym %0d", sym);
        end
        @(posedge clk_i);
        #1;
        bus.in_valid_i = 1'b0;
        $display("send sym=%0d", sym);
    endtask

    task automatic drain();
        int waited = 0;
        while (exp_q.size() != 0 && waited < 2000) begin
            waited++;
            @(negedge clk_i);
        end
        if (exp_q.size() != 0) check("drain_timeout", exp_q.size(), 0);
        @(posedge clk_i);
        #1;
    endtask

    task automatic pulse_clear();
        bus.soft_clear_i = 1'b1;
        @(posedge clk_i);
        #1;
        bus.soft_clear_i = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        rst_i             = 1'b1;
        bus.soft_clear_i  = 1'b0;
        bus.running_i     = 1'b1;
        bus.window_mode_i = 1'b1;
        bus.sig_mode_i    = 1'b0;
        bus.win_size_i    = WIN_W'(3);
        bus.stride_i      = WIN_W'(1);
        bus.shift_in_i    = '0;
        bus.in_valid_i    = 1'b0;
        bus.in_symbol_i   = '0;
        bus.out_ready_i   = 1'b1;
        repeat (2) @(posedge clk_i);
        #1 rst_i = 1'b0;

        @(negedge clk_i);
        check("reset_out_valid", int'(bus.out_valid_o), 0);
        check("reset_symbol",    int'(bus.out_symbol_o), 0);
        check("reset_shift",     int'(bus.out_shift_o), 0);
        check("reset_zero",      int'(bus.out_zero_o), 0);
        check("reset_last",      int'(bus.out_last_o), 0);
        check("reset_in_ready",  int'(bus.in_ready_o), 1);
        @(posedge clk_i);
        #1;

        // Basic window, win=3 stride=1 sig=0
        push(5,0,0,0); push(0,1,1,0); push(0,2,1,1);
        push(9,0,0,0); push(5,1,0,0); push(0,2,1,1);
        push(2,0,0,0); push(9,1,0,0); push(5,2,0,1);
        send_sym(5); send_sym(9); send_sym(2);
        drain();

        // Signature shifts
        pulse_clear();
        bus.sig_mode_i = 1'b1;
        push(5,0,0,0);  push(0,6,1,0);  push(0,7,1,1);
        push(9,5,0,0);  push(5,10,0,0); push(0,14,1,1);
        push(2,12,0,0); push(9,8,0,0);  push(5,13,0,1);
        send_sym(5); send_sym(9); send_sym(2);
        drain();

        // Stride 2, full window, shift wraps modulo 64
        pulse_clear();
        bus.win_size_i = WIN_W'(16);
        bus.stride_i   = WIN_W'(2);
        send_sym(60);
        @(negedge clk_i);
        check("stride_no_early_window", int'(bus.out_valid_o), 0);
        check("stride_still_loading",   int'(bus.in_ready_o), 1);
        @(posedge clk_i);
        #1;
        push(3,60,0,0); push(60,4,0,0);
        for (int k = 2; k < 16; k++) push(0, k - 1, 1, (k == 15) ? 1 : 0);
        send_sym(3);
        drain();

        // Backpressure mid-window
        pulse_clear();
        bus.win_size_i = WIN_W'(3);
        bus.stride_i   = WIN_W'(1);
        bus.sig_mode_i = 1'b0;
        push(7,0,0,0); push(0,1,1,0); push(0,2,1,1);
        bus.out_ready_i = 1'b0;
        send_sym(7);
        @(posedge clk_i);
        #1 bus.out_ready_i = 1'b1;
        @(posedge clk_i);
        #1 bus.out_ready_i = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk_i);
            check("stall_valid",    int'(bus.out_valid_o), 1);
            check("stall_symbol",   int'(bus.out_symbol_o), 0);
            check("stall_shift",    int'(bus.out_shift_o), 1);
            check("stall_zero",     int'(bus.out_zero_o), 1);
            check("stall_last",     int'(bus.out_last_o), 0);
            check("stall_in_ready", int'(bus.in_ready_o), 0);
        end
        @(posedge clk_i);
        #1 bus.out_ready_i = 1'b1;
        drain();

        // Asynchronous reset mid-EMIT
        pulse_clear();
        push(4,0,0,0); push(0,1,1,0); push(0,2,1,1);
        send_sym(4);
        drain();
        bus.out_ready_i = 1'b0;
        send_sym(8);
        @(negedge clk_i);
        check("pre_reset_valid",  int'(bus.out_valid_o), 1);
        check("pre_reset_symbol", int'(bus.out_symbol_o), 8);
        #2 rst_i = 1'b1;
        #1;
        check("async_reset_valid",  int'(bus.out_valid_o), 0);
        check("async_reset_symbol", int'(bus.out_symbol_o), 0);
        check("async_reset_zero",   int'(bus.out_zero_o), 0);
        check("async_reset_last",   int'(bus.out_last_o), 0);
        @(posedge clk_i);
        #1 rst_i = 1'b0;
        bus.out_ready_i = 1'b1;
        push(6,0,0,0); push(0,1,1,0); push(0,2,1,1);
        send_sym(6);
        drain();

        // Soft clear mid-LOAD discards the partial stride
        bus.stride_i = WIN_W'(2);
        send_sym(1);
        pulse_clear();
        @(negedge clk_i);
        check("clear_out_valid", int'(bus.out_valid_o), 0);
        check("clear_in_ready",  int'(bus.in_ready_o), 1);
        @(posedge clk_i);
        #1;
        push(5,0,0,0); push(3,1,0,0); push(0,2,1,1);
        send_sym(3); send_sym(5);
        drain();

        // Pass-through, back-to-back
        bus.window_mode_i = 1'b0;
        bus.shift_in_i    = SHIFT_W'(7);
        push(1,7,0,1); push(2,7,0,1); push(3,7,0,1);
        base = n_beats;
        for (int i = 1; i <= 3; i++) begin
            bus.in_valid_i  = 1'b1;
            bus.in_symbol_i = SYM_W'(i);
            @(negedge clk_i);
            check("pt_in_ready", int'(bus.in_ready_o), 1);
            @(posedge clk_i);
            #1;
        end
        bus.in_valid_i = 1'b0;
        @(negedge clk_i);
        #1;
        check("pt_full_rate_beats", n_beats - base, 3);
        @(posedge clk_i);
        #1;

        // Pass-through stall
        bus.out_ready_i = 1'b0;
        push(9,7,0,1);
        bus.in_valid_i  = 1'b1;
        bus.in_symbol_i = SYM_W'(9);
        @(negedge clk_i);
        check("pt_stall_accept", int'(bus.in_ready_o), 1);
        @(posedge clk_i);
        #1 bus.in_valid_i = 1'b0;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk_i);
            check("pt_stall_valid",    int'(bus.out_valid_o), 1);
            check("pt_stall_symbol",   int'(bus.out_symbol_o), 9);
            check("pt_stall_in_ready", int'(bus.in_ready_o), 0);
            @(posedge clk_i);
            #1;
        end
        bus.out_ready_i = 1'b1;
        drain();

        // running_i=0 blocks input
        bus.running_i   = 1'b0;
        bus.in_valid_i  = 1'b1;
        bus.in_symbol_i = SYM_W'(11);
        @(negedge clk_i);
        check("not_running_in_ready", int'(bus.in_ready_o), 0);
        @(posedge clk_i);
        #1;
        @(negedge clk_i);
        check("not_running_no_beat", int'(bus.out_valid_o), 0);
        @(posedge clk_i);
        #1;
        bus.in_valid_i = 1'b0;
        bus.running_i  = 1'b1;
        repeat (2) @(posedge clk_i);

        check("scoreboard_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
